temp_sample_sequencer: RTL and testbench

Hardware sequencer that samples the temperature sensor periodically without CPU involvement. It arms the timer peripheral, starts a sensor conversion when the interval expires, and averages 2^AVG_LOG2 conversions. Each average is published to a status register and written to the 7-segment display register. It sits in `Top` between the CPU's memory-mapped control bits and the existing timer, sensor and display peripherals, driving their start, limit and write-enable inputs.

---
 rtl/temp_sample_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_temp_sample_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_sequencer.sv
// Periodic temperature sampling sequencer: arms the timer, triggers sensor
// conversions, averages 2^AVG_LOG2 results and publishes them to status/display.
module temp_sample_sequencer #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        clear_err,
  output logic        timer_start,
  output logic [31:0] timer_limit,
  input  logic        timer_done,
  output logic        temp_start,
  input  logic        temp_done,
  input  logic [15:0] temp_data,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        seg_we,
  output logic [31:0] seg_wdata,
  output logic        busy,
  output logic        error
);

  localparam int unsigned ACC_W = 16 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] N_AVG    = CNT_W'(1 << AVG_LOG2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_T,
    S_CONV,
    S_WAIT_C
  } state_e;

  state_e             state_q, state_d;
  logic               timer_start_q, timer_start_d;
  logic [31:0]        timer_limit_q, timer_limit_d;
  logic               temp_start_q, temp_start_d;
  logic [15:0]        sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic               seg_we_q, seg_we_d;
  logic [31:0]        seg_wdata_q, seg_wdata_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               timer_done_prev_q, timer_done_prev_d;
  logic               temp_done_prev_q, temp_done_prev_d;

  logic               timer_rise;
  logic               temp_rise;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt_inc;

  // Rising-edge detection on done levels and the running sum/count candidates
  always_comb begin
    timer_rise = timer_done & ~timer_done_prev_q;
    temp_rise  = temp_done & ~temp_done_prev_q;
    acc_sum    = acc_q + ACC_W'(temp_data);
    cnt_inc    = cnt_q + CNT_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d           = state_q;
    timer_start_d     = 1'b0;
    temp_start_d      = 1'b0;
    sample_valid_d    = 1'b0;
    seg_we_d          = 1'b0;
    timer_limit_d     = timer_limit_q;
    sample_d          = sample_q;
    seg_wdata_d       = seg_wdata_q;
    error_d           = error_q;
    acc_d             = acc_q;
    cnt_d             = cnt_q;
    tmo_d             = tmo_q;
    timer_done_prev_d = timer_done;
    temp_done_prev_d  = temp_done;

    if (clear_err) begin
      error_d = 1'b0;
    end

    if (!enable) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Timer is armed on the way into ARM so its pulse lands one cycle after enable
          state_d       = S_ARM;
          timer_limit_d = period;
          timer_start_d = (period != 32'd0);
        end
        S_ARM: begin
          // A high timer_start_q means the arm already went out on entry from IDLE
          if (timer_start_q) begin
            state_d = S_WAIT_T;
          end else begin
            timer_limit_d = period;
            if (period != 32'd0) begin
              timer_start_d = 1'b1;
              state_d       = S_WAIT_T;
            end else begin
              temp_start_d = 1'b1;
              state_d      = S_CONV;
            end
          end
        end
        S_WAIT_T: begin
          if (timer_rise) begin
            temp_start_d = 1'b1;
            state_d      = S_CONV;
          end
        end
        S_CONV: begin
          tmo_d   = '0;
          state_d = S_WAIT_C;
        end
        S_WAIT_C: begin
          if (temp_rise) begin
            state_d = S_ARM;
            if (cnt_inc == N_AVG) begin
              sample_d       = 16'(acc_sum >> AVG_LOG2);
              seg_wdata_d    = {16'h0, 16'(acc_sum >> AVG_LOG2)};
              sample_valid_d = 1'b1;
              seg_we_d       = 1'b1;
              acc_d          = '0;
              cnt_d          = '0;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_inc;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Sensor timeout: discard the partial average and keep sampling
            error_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ARM;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      timer_start_q     <= 1'b0;
      timer_limit_q     <= '0;
      temp_start_q      <= 1'b0;
      sample_q          <= '0;
      sample_valid_q    <= 1'b0;
      seg_we_q          <= 1'b0;
      seg_wdata_q       <= '0;
      busy_q            <= 1'b0;
      error_q           <= 1'b0;
      acc_q             <= '0;
      cnt_q             <= '0;
      tmo_q             <= '0;
      timer_done_prev_q <= 1'b0;
      temp_done_prev_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_start_q     <= timer_start_d;
      timer_limit_q     <= timer_limit_d;
      temp_start_q      <= temp_start_d;
      sample_q          <= sample_d;
      sample_valid_q    <= sample_valid_d;
      seg_we_q          <= seg_we_d;
      seg_wdata_q       <= seg_wdata_d;
      busy_q            <= busy_d;
      error_q           <= error_d;
      acc_q             <= acc_d;
      cnt_q             <= cnt_d;
      tmo_q             <= tmo_d;
      timer_done_prev_q <= timer_done_prev_d;
      temp_done_prev_q  <= temp_done_prev_d;
    end
  end

  assign timer_start  = timer_start_q;
  assign timer_limit  = timer_limit_q;
  assign temp_start   = temp_start_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign seg_we       = seg_we_q;
  assign seg_wdata    = seg_wdata_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// Self-checking bench for temp_sample_sequencer: bench drives timer/sensor,
// expected averages are queued on stimulus and compared when published.
module tb_temp_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] period;
  logic        clear_err;
  logic        timer_start;
  logic [31:0] timer_limit;
  logic        timer_done;
  logic        temp_start;
  logic        temp_done;
  logic [15:0] temp_data;
  logic [15:0] sample;
  logic        sample_valid;
  logic        seg_we;
  logic [31:0] seg_wdata;
  logic        busy;
  logic        error;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_pub = 0;
  logic [15:0] exp_q[$];
  int unsigned m_acc;
  int unsigned m_cnt;
  int unsigned arm_per;
  int          waited;

  temp_sample_sequencer #(.AVG_LOG2(2), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .clear_err    (clear_err),
    .timer_start  (timer_start),
    .timer_limit  (timer_limit),
    .timer_done   (timer_done),
    .temp_start   (temp_start),
    .temp_done    (temp_done),
    .temp_data    (temp_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .seg_we       (seg_we),
    .seg_wdata    (seg_wdata),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion from the cycle where the arm pulse (or, with period 0, the
  // conversion pulse) is visible, through to the next arm.
  task automatic run_conv(input logic [15:0] d);
    bit pub;
    if (arm_per != 0) begin
      tick();
      check_eq("ts_width", {31'd0, timer_start}, 32'd0);
      timer_done = 1'b1;
      tick();
      check_eq("conv_lat", {31'd0, temp_start}, 32'd1);
      timer_done = 1'b0;
    end
    tick();
    check_eq("cs_width", {31'd0, temp_start}, 32'd0);
    temp_data = d;
    temp_done = 1'b1;
    m_acc += d;
    m_cnt++;
    pub = (m_cnt == 4);
    if (pub) begin
      exp_q.push_back(16'(m_acc >> 2));
      m_acc = 0;
      m_cnt = 0;
    end
    tick();
    temp_done = 1'b0;
    check_eq("pub_lat", {31'd0, sample_valid}, {31'd0, pub});
    arm_per = period;
    tick();
    if (arm_per != 0) begin
      check_eq("rearm", {31'd0, timer_start}, 32'd1);
      check_eq("limit", timer_limit, arm_per);
    end else begin
      check_eq("no_ts", {31'd0, timer_start}, 32'd0);
      check_eq("conv0", {31'd0, temp_start}, 32'd1);
    end
  endtask

  // Scoreboard: every publish must match the oldest queued average
  always @(negedge clk) begin
    if (!reset && (sample_valid || seg_we)) begin
      n_pub++;
      check_eq("seg_we", {31'd0, seg_we}, {31'd0, sample_valid});
      if (exp_q.size() == 0) begin
        check_eq("unexp_pub", exp_q.size(), 32'd1);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check_eq("sample", {16'd0, sample}, {16'd0, e});
        check_eq("seg_wdata", seg_wdata, {16'h0, e});
      end
    end
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    period    = 32'd100;
    clear_err = 1'b0;
    timer_done = 1'b0;
    temp_done = 1'b0;
    temp_data = 16'd0;
    m_acc     = 0;
    m_cnt     = 0;
    arm_per   = 0;

    // Reset held with enable high: everything quiet
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pulses", {28'd0, timer_start, temp_start, sample_valid, seg_we}, 32'd0);
    check_eq("rst_limit", timer_limit, 32'd0);
    check_eq("rst_sample", {16'd0, sample}, 32'd0);
    check_eq("rst_segw", seg_wdata, 32'd0);
    check_eq("rst_busy_err", {30'd0, busy, error}, 32'd0);

    reset = 1'b0;
    tick();
    check_eq("first_ts", {31'd0, timer_start}, 32'd1);
    check_eq("first_limit", timer_limit, 32'd100);
    check_eq("first_busy", {31'd0, busy}, 32'd1);
    arm_per = 100;
    period  = 32'd10;

    // Four-sample average: 407 >> 2 = 101
    run_conv(16'd100);
    run_conv(16'd101);
    run_conv(16'd102);
    run_conv(16'd104);
    check_eq("avg_sample", {16'd0, sample}, 32'd101);
    check_eq("avg_segw", seg_wdata, 32'h0000_0065);

    // Zero period: conversions back to back with no timer arm
    period = 32'd0;
    run_conv(16'd200);
    run_conv(16'd300);
    run_conv(16'd400);
    run_conv(16'd503);
    run_conv(16'd7);
    run_conv(16'd9);

    // Sensor never answers: sticky error 17 cycles after temp_start
    period = 32'd10;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!error && waited < 40);
    check_eq("tmo_lat", waited, 32'd17);
    m_acc = 0;
    m_cnt = 0;
    tick();
    check_eq("tmo_rearm", {31'd0, timer_start}, 32'd1);
    check_eq("err_sticky", {31'd0, error}, 32'd1);
    arm_per = 10;

    // Partial sum was discarded: 10+20+30+40 = 100 >> 2 = 25
    clear_err = 1'b1;
    run_conv(16'd10);
    clear_err = 1'b0;
    check_eq("err_clear", {31'd0, error}, 32'd0);
    run_conv(16'd20);
    run_conv(16'd30);
    run_conv(16'd40);

    // Drop enable in WAIT_C after three samples
    run_conv(16'd1);
    run_conv(16'd2);
    run_conv(16'd3);
    tick();
    timer_done = 1'b1;
    tick();
    check_eq("drop_conv", {31'd0, temp_start}, 32'd1);
    timer_done = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    check_eq("busy_fall", {31'd0, busy}, 32'd0);
    check_eq("sample_hold", {16'd0, sample}, 32'd25);
    check_eq("idle_quiet", {29'd0, timer_start, temp_start, sample_valid}, 32'd0);
    m_acc = 0;
    m_cnt = 0;
    tick();
    tick();

    // Re-enable restarts with a fresh interval and a fresh average (50 >> 2 = 12)
    enable = 1'b1;
    tick();
    check_eq("reen_ts", {31'd0, timer_start}, 32'd1);
    check_eq("reen_limit", timer_limit, 32'd10);
    arm_per = 10;
    run_conv(16'd11);
    run_conv(16'd12);
    run_conv(16'd13);
    run_conv(16'd14);

    // timer_done left high from the previous interval must not start a conversion
    tick();
    timer_done = 1'b1;
    tick();
    check_eq("stale_conv1", {31'd0, temp_start}, 32'd1);
    tick();
    temp_data = 16'd77;
    temp_done = 1'b1;
    m_acc += 77;
    m_cnt++;
    tick();
    temp_done = 1'b0;
    tick();
    check_eq("stale_arm", {31'd0, timer_start}, 32'd1);
    repeat (4) begin
      tick();
      check_eq("stale_hold", {31'd0, temp_start}, 32'd0);
    end
    timer_done = 1'b0;
    tick();
    check_eq("stale_low", {31'd0, temp_start}, 32'd0);
    timer_done = 1'b1;
    tick();
    check_eq("stale_edge", {31'd0, temp_start}, 32'd1);
    timer_done = 1'b0;
    tick();

    // Asynchronous reset mid-conversion clears outputs immediately
    reset = 1'b1;
    #1;
    check_eq("arst_pulses", {28'd0, timer_start, temp_start, sample_valid, seg_we}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_sample", {16'd0, sample}, 32'd0);
    tick();

    check_eq("pub_count", n_pub, 32'd4);
    check_eq("queue_left", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
